// File: rtl/led_adder_pkg.sv
// Shared types and constants for the switch-driven LED adder.
// Holds the FSM state encoding, display width and switch indices.
package led_adder_pkg;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      CALC    = 2'd2,
      SHOW    = 2'd3
   } state_t;

   localparam int LED_W  = 4;
   localparam int N_SW   = 4;

   localparam int SW_INC = 0;
   localparam int SW_ADV = 1;
   localparam int SW_DEC = 2;
   localparam int SW_CLR = 3;

endpackage

// File: rtl/switch_debounce.sv
// One push-switch input path: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on the debounced rise.
// Ports: i_Clk, i_Rst_n (async, active low), i_Switch (raw), o_Press.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Switch,
   output logic o_Press
);

   localparam int CNT_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_Switch;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            // Input held stable long enough: accept it.
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Rise only; releases produce no event.
   assign o_Press = r_level & ~r_level_d;

endmodule

// File: rtl/led_adder_ctrl.sv
// Sequencer for the LED adder: debounced switches edit A/B, the external
// adder sum is latched in CALC and the LEDs show operand or result.
// Ports: i_Clk, i_Rst_n, i_Switch_1..4, o_Op_A, o_Op_B, i_Sum,
//        o_State, o_LED_1 (MSB) .. o_LED_4 (LSB).
module led_adder_ctrl #(
   parameter int DATA_W          = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Switch_1,
   input  logic              i_Switch_2,
   input  logic              i_Switch_3,
   input  logic              i_Switch_4,
   output logic [DATA_W-1:0] o_Op_A,
   output logic [DATA_W-1:0] o_Op_B,
   input  logic [DATA_W:0]   i_Sum,
   output logic [1:0]        o_State,
   output logic              o_LED_1,
   output logic              o_LED_2,
   output logic              o_LED_3,
   output logic              o_LED_4
);

   import led_adder_pkg::*;

   localparam int BL_W =
      (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BL_W-1:0] BL_MAX =
      BL_W'(BLINK_CYCLES - 1);

   logic [N_SW-1:0]   w_raw;
   logic [N_SW-1:0]   w_press;
   logic              w_step;
   logic              w_up;
   logic              w_enter_b;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W:0]   r_sum;
   logic [DATA_W-1:0] w_a_nxt;
   logic [DATA_W-1:0] w_b_nxt;
   logic [DATA_W:0]   w_sum_nxt;

   logic [BL_W-1:0]   r_blink_cnt;
   logic              r_blink_on;
   logic [LED_W-1:0]  w_disp;
   logic [LED_W-1:0]  r_disp;

   assign w_raw = {i_Switch_4, i_Switch_3,
                   i_Switch_2, i_Switch_1};

   for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .i_Clk   (i_Clk),
         .i_Rst_n (i_Rst_n),
         .i_Switch(w_raw[gi]),
         .o_Press (w_press[gi])
      );
   end

   // Inc and dec together cancel out.
   assign w_step = w_press[SW_INC] ^ w_press[SW_DEC];
   assign w_up   = w_press[SW_INC];

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state <= ENTER_A;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_sum   <= w_sum_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_sum_nxt   = r_sum;
      if (w_press[SW_CLR]) begin
         w_state_nxt = ENTER_A;
         w_a_nxt     = '0;
         w_b_nxt     = '0;
         w_sum_nxt   = '0;
      end else begin
         unique case (r_state)
            ENTER_A: begin
               if (w_press[SW_ADV])
                  w_state_nxt = ENTER_B;
               else if (w_step)
                  w_a_nxt = w_up ? r_a + 1'b1 : r_a - 1'b1;
            end
            ENTER_B: begin
               if (w_press[SW_ADV])
                  w_state_nxt = CALC;
               else if (w_step)
                  w_b_nxt = w_up ? r_b + 1'b1 : r_b - 1'b1;
            end
            CALC: begin
               w_sum_nxt   = i_Sum;
               w_state_nxt = SHOW;
            end
            SHOW: begin
               if (w_press[SW_ADV])
                  w_state_nxt = ENTER_A;
            end
            default: w_state_nxt = ENTER_A;
         endcase
      end
   end

   assign w_enter_b = (w_state_nxt == ENTER_B) &&
                      (r_state != ENTER_B);

   // Blink restarts in the on phase each time ENTER_B is entered.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b0;
      end else if (w_enter_b) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_state == ENTER_B) begin
         if (r_blink_cnt == BL_MAX) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
         end
      end
   end

   always_comb begin
      w_disp = '0;
      unique case (r_state)
         ENTER_A: w_disp = LED_W'(r_a);
         ENTER_B: w_disp = r_blink_on ? LED_W'(r_b) : '0;
         default: w_disp = LED_W'(r_sum);
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n)
         r_disp <= '0;
      else
         r_disp <= w_disp;
   end

   assign o_Op_A  = r_a;
   assign o_Op_B  = r_b;
   assign o_State = r_state;
   assign o_LED_1 = r_disp[3];
   assign o_LED_2 = r_disp[2];
   assign o_LED_3 = r_disp[1];
   assign o_LED_4 = r_disp[0];

endmodule

// File: tb/tb_led_adder_ctrl.sv
// Self-checking bench for led_adder_ctrl with a behavioural adder
// and a rule-level model of operands, sum and state.
module tb_led_adder_ctrl;

   localparam int DW  = 2;
   localparam int DEB = 4;
   localparam int BLK = 8;

   logic          clk;
   logic          rst_n;
   logic          sw1, sw2, sw3, sw4;
   logic [DW-1:0] op_a, op_b;
   logic [DW:0]   sum;
   logic [1:0]    st;
   logic          l1, l2, l3, l4;
   logic [3:0]    d;

   int n_checks;
   int n_fail;

   // Model
   int m_a, m_b, m_s, m_st;

   led_adder_ctrl #(
      .DATA_W(DW),
      .DEBOUNCE_CYCLES(DEB),
      .BLINK_CYCLES(BLK)
   ) dut (
      .i_Clk     (clk),
      .i_Rst_n   (rst_n),
      .i_Switch_1(sw1),
      .i_Switch_2(sw2),
      .i_Switch_3(sw3),
      .i_Switch_4(sw4),
      .o_Op_A    (op_a),
      .o_Op_B    (op_b),
      .i_Sum     (sum),
      .o_State   (st),
      .o_LED_1   (l1),
      .o_LED_2   (l2),
      .o_LED_3   (l3),
      .o_LED_4   (l4)
   );

   assign sum = {1'b0, op_a} + {1'b0, op_b};
   assign d   = {l1, l2, l3, l4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mask bit0=sw1 inc, bit1=sw2 adv, bit2=sw3 dec, bit3=sw4 clr
   task automatic model_step(input logic [3:0] mk);
      if (mk[3]) begin
         m_a = 0; m_b = 0; m_s = 0; m_st = 0;
      end else if (mk[1]) begin
         if (m_st == 0) m_st = 1;
         else if (m_st == 1) begin
            m_s = m_a + m_b; m_st = 3;
         end else if (m_st == 3) m_st = 0;
      end else if (m_st < 2 && (mk[0] != mk[2])) begin
         if (m_st == 0) m_a = (m_a + (mk[0] ? 1 : 3)) % 4;
         else           m_b = (m_b + (mk[0] ? 1 : 3)) % 4;
      end
   endtask

   function automatic logic [3:0] exp_disp();
      if (m_st == 0) return 4'(m_a);
      if (m_st == 1) return 4'(m_b);
      return 4'(m_s);
   endfunction

   task automatic drive(input logic [3:0] mk);
      sw1 = mk[0]; sw2 = mk[1]; sw3 = mk[2]; sw4 = mk[3];
   endtask

   task automatic do_press(input logic [3:0] mk, input int hold);
      @(posedge clk); #1;
      drive(mk);
      repeat (hold) @(posedge clk);
      #1 drive(4'b0000);
      repeat (12) @(posedge clk);
      model_step(mk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(4'b0000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      m_a = 0; m_b = 0; m_s = 0; m_st = 0;
      @(negedge clk);
      n_checks++;
      if (d !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_led got=%b exp=0000", d);
      end
      n_checks++;
      if (st !== 2'd0 || op_a !== '0 || op_b !== '0) begin
         n_fail++;
         $display("FAIL reset_regs got st=%0d a=%0d b=%0d exp 0/0/0",
                  st, op_a, op_b);
      end
      do_press(4'b0001, 10);
      n_checks++;
      if (op_a !== 2'd1) begin
         n_fail++;
         $display("FAIL pre_reset_a got=%0d exp=1", op_a);
      end
      // Start a second press, then reset mid-debounce.
      @(posedge clk); #1 sw1 = 1'b1;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      m_a = 0; m_b = 0; m_s = 0; m_st = 0;
      n_checks++;
      if (op_a !== '0 || st !== 2'd0 || d !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset got a=%0d st=%0d d=%b exp 0/0/0000",
                  op_a, st, d);
      end
      sw1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (op_a !== '0 || d !== 4'b0000) begin
         n_fail++;
         $display("FAIL late_press got a=%0d d=%b exp a=0 d=0000",
                  op_a, d);
      end
   endtask

   task automatic test_debounce();
      @(posedge clk); #1 sw1 = 1'b1;
      repeat (2) @(posedge clk);
      #1 sw1 = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (op_a !== 2'd0) begin
         n_fail++;
         $display("FAIL glitch got a=%0d exp=0", op_a);
      end
      do_press(4'b0001, 10);
      n_checks++;
      if (op_a !== 2'(m_a)) begin
         n_fail++;
         $display("FAIL hold10 got a=%0d exp=%0d", op_a, m_a);
      end
      for (int i = 0; i < 3; i++) begin
         do_press(4'b0001, $urandom_range(9, 30));
         n_checks++;
         if (op_a !== 2'(m_a)) begin
            n_fail++;
            $display("FAIL one_per_hold got a=%0d exp=%0d", op_a, m_a);
         end
      end
   endtask

   task automatic test_operand();
      do_press(4'b1000, 10);
      for (int i = 0; i < 3; i++) do_press(4'b0001, 10);
      n_checks++;
      if (op_a !== 2'd3 || d !== 4'b0011) begin
         n_fail++;
         $display("FAIL a_three got a=%0d d=%b exp 3/0011", op_a, d);
      end
      do_press(4'b0001, 10);
      n_checks++;
      if (op_a !== 2'd0 || d !== 4'b0000) begin
         n_fail++;
         $display("FAIL a_wrap_up got a=%0d d=%b exp 0/0000", op_a, d);
      end
      do_press(4'b0100, 10);
      n_checks++;
      if (op_a !== 2'd3 || d !== 4'b0011) begin
         n_fail++;
         $display("FAIL a_wrap_dn got a=%0d d=%b exp 3/0011", op_a, d);
      end
      for (int i = 0; i < 8; i++) begin
         do_press($urandom_range(0, 1) ? 4'b0001 : 4'b0100, 10);
         n_checks++;
         if (op_a !== 2'(m_a) || d !== exp_disp()) begin
            n_fail++;
            $display("FAIL a_rand got a=%0d d=%b exp %0d/%b",
                     op_a, d, m_a, exp_disp());
         end
      end
      do_press(4'b1000, 10);
      for (int i = 0; i < 3; i++) do_press(4'b0001, 10);
   endtask

   task automatic test_blink_calc();
      logic [3:0] cur;
      int run, nrun;
      bit found;
      do_press(4'b0010, 10);
      do_press(4'b0001, 10);
      do_press(4'b0001, 10);
      n_checks++;
      if (st !== 2'd1 || op_b !== 2'd2 || op_a !== 2'd3) begin
         n_fail++;
         $display("FAIL enter_b got st=%0d a=%0d b=%0d exp 1/3/2",
                  st, op_a, op_b);
      end
      cur = d; run = 0; nrun = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_checks++;
         if (d !== 4'b0010 && d !== 4'b0000) begin
            n_fail++;
            $display("FAIL blink_val got=%b exp 0010|0000", d);
         end
         if (d === cur) run++;
         else begin
            if (nrun > 0) begin
               n_checks++;
               if (run != BLK) begin
                  n_fail++;
                  $display("FAIL blink_len got=%0d exp=%0d", run, BLK);
               end
            end
            nrun++; cur = d; run = 1;
         end
      end
      n_checks++;
      if (nrun < 3) begin
         n_fail++;
         $display("FAIL blink_toggles got=%0d exp>=3", nrun);
      end
      @(posedge clk); #1 sw2 = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (st !== 2'd1) found = 1;
      end
      n_checks++;
      if (!found || st !== 2'd2) begin
         n_fail++;
         $display("FAIL calc_entry got st=%0d exp=2", st);
      end
      @(negedge clk);
      n_checks++;
      if (st !== 2'd3) begin
         n_fail++;
         $display("FAIL calc_1clk got st=%0d exp=3", st);
      end
      sw2 = 1'b0;
      model_step(4'b0010);
      repeat (12) @(negedge clk);
      n_checks++;
      if (d !== 4'(m_s) || d !== 4'b0101) begin
         n_fail++;
         $display("FAIL show_sum got d=%b exp 0101", d);
      end
   endtask

   task automatic test_show();
      bit found;
      do_press(4'b0001, 10);
      do_press(4'b0100, 10);
      n_checks++;
      if (st !== 2'd3 || op_a !== 2'd3 || op_b !== 2'd2 ||
          d !== 4'b0101) begin
         n_fail++;
         $display("FAIL show_ignore got st=%0d a=%0d b=%0d d=%b exp 3/3/2/0101",
                  st, op_a, op_b, d);
      end
      do_press(4'b0010, 10);
      n_checks++;
      if (st !== 2'd0 || op_a !== 2'd3 || op_b !== 2'd2 ||
          d !== 4'b0011) begin
         n_fail++;
         $display("FAIL show_exit got st=%0d a=%0d b=%0d d=%b exp 0/3/2/0011",
                  st, op_a, op_b, d);
      end
      @(posedge clk); #1 sw2 = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (st === 2'd1) found = 1;
      end
      sw2 = 1'b0;
      model_step(4'b0010);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reenter_b got st=%0d exp=1", st);
      end
      for (int i = 0; i < 2 * BLK; i++) begin
         @(negedge clk);
         n_checks++;
         if (d !== ((i < BLK) ? 4'b0010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL blink_phase i=%0d got=%b exp=%b", i, d,
                     (i < BLK) ? 4'b0010 : 4'b0000);
         end
      end
   endtask

   task automatic test_simul();
      do_press(4'b0101, 10);
      n_checks++;
      if (st !== 2'd1 || op_b !== 2'd2) begin
         n_fail++;
         $display("FAIL inc_dec got st=%0d b=%0d exp 1/2", st, op_b);
      end
      do_press(4'b1010, 10);
      n_checks++;
      if (st !== 2'd0 || op_a !== '0 || op_b !== '0 ||
          d !== 4'b0000) begin
         n_fail++;
         $display("FAIL clr_wins got st=%0d a=%0d b=%0d d=%b exp 0/0/0/0000",
                  st, op_a, op_b, d);
      end
   endtask

   task automatic test_random();
      logic [3:0] mk;
      for (int i = 0; i < 40; i++) begin
         mk = 4'($urandom_range(1, 15));
         if (mk[3] && $urandom_range(0, 3) != 0) mk[3] = 1'b0;
         if (mk == 4'b0000) mk = 4'b0001;
         do_press(mk, $urandom_range(9, 16));
         n_checks++;
         if (st !== 2'(m_st) || op_a !== 2'(m_a) ||
             op_b !== 2'(m_b)) begin
            n_fail++;
            $display("FAIL rand_regs mk=%b got st=%0d a=%0d b=%0d exp %0d/%0d/%0d",
                     mk, st, op_a, op_b, m_st, m_a, m_b);
         end
         n_checks++;
         if (m_st == 1 ? (d !== exp_disp() && d !== 4'b0000)
                       : (d !== exp_disp())) begin
            n_fail++;
            $display("FAIL rand_disp mk=%b got=%b exp=%b", mk, d,
                     exp_disp());
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(4'b0000);
      rst_n = 1'b0;
      test_reset();
      test_debounce();
      test_operand();
      test_blink_calc();
      test_show();
      test_simul();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
